// File: rtl/iod_eye_train_ctrl.sv
// Multi-lane IOD eye-centring controller. Sweeps one lane's delay line from
// tap 0 upward, scores each tap clean/dirty from the eye-monitor flags, keeps
// the first widest clean run, then walks the line back to the run's centre.
// Lanes are trained one after another; every output is a register.
module iod_eye_train_ctrl #(
  parameter int NUM_LANES     = 1,
  parameter int TAP_W         = 7,
  parameter int NUM_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_WINDOW    = 4
) (
  input  logic                       FAB_CLK,
  input  logic                       RESET,
  input  logic                       TRAIN_START,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  output logic                       TRAIN_BUSY,
  output logic                       TRAIN_DONE,
  output logic                       TRAIN_ERR,
  output logic [NUM_LANES-1:0]       LANE_FAIL,
  output logic [NUM_LANES*TAP_W-1:0] LANE_TAP
);

  localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LEN_W   = TAP_W + 1;

  localparam logic [TAP_W-1:0]  LAST_TAP    = TAP_W'(NUM_TAPS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [LEN_W-1:0]  MIN_LEN     = LEN_W'(MIN_WINDOW);

  typedef enum logic [3:0] {
    IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, CENTER, FAIL, NEXT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [LANE_W-1:0] lane_q;
  logic [TAP_W-1:0]  tap_q, target_q, run_start_q, best_start_q;
  logic [LEN_W-1:0]  run_len_q, best_len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dirty_q, oor_q, phase_q;

  // Run tracking for the tap just sampled; only committed in EVAL.
  logic              flag_hit, oor_hit, sweep_end;
  logic [LEN_W-1:0]  run_len_d, best_len_d;
  logic [TAP_W-1:0]  run_start_d, best_start_d, target_d;

  assign flag_hit  = EYE_MONITOR_EARLY[lane_q] | EYE_MONITOR_LATE[lane_q];
  assign oor_hit   = DELAY_LINE_OUT_OF_RANGE[lane_q];
  assign sweep_end = (tap_q == LAST_TAP) || oor_q;

  // Extend or break the current clean run; a strictly longer run replaces the best.
  always_comb begin
    run_len_d    = dirty_q ? '0 : run_len_q + 1'b1;
    run_start_d  = (!dirty_q && run_len_q == '0) ? tap_q : run_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    if (run_len_d > best_len_q) begin
      best_len_d   = run_len_d;
      best_start_d = run_start_d;
    end
    target_d = best_start_d + TAP_W'((best_len_d - 1'b1) >> 1);
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (TRAIN_START) state_d = LOAD;
      LOAD:       state_d = CLEAR;
      CLEAR:      state_d = SETTLE;
      SETTLE:     if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:     if (cnt_q == SAMPLE_LAST) state_d = EVAL;
      EVAL: begin
        if (sweep_end) state_d = (best_len_d >= MIN_LEN) ? CENTER : FAIL;
        else           state_d = STEP;
      end
      STEP:       state_d = CLEAR;
      CENTER:     if (tap_q <= target_q) state_d = NEXT;
      FAIL:       state_d = NEXT;
      NEXT:       state_d = (lane_q == LAST_LANE) ? DONE : LOAD;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge FAB_CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Registered strobes, results and per-lane sweep bookkeeping.
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      EYE_MONITOR_CLEAR_FLAGS <= '0;
      DELAY_LINE_MOVE         <= '0;
      DELAY_LINE_DIRECTION    <= '0;
      DELAY_LINE_LOAD         <= '0;
      TRAIN_BUSY              <= 1'b0;
      TRAIN_DONE              <= 1'b0;
      TRAIN_ERR               <= 1'b0;
      LANE_FAIL               <= '0;
      LANE_TAP                <= '0;
      lane_q                  <= '0;
      phase_q                 <= 1'b0;
    end else begin
      EYE_MONITOR_CLEAR_FLAGS <= '0;
      DELAY_LINE_MOVE         <= '0;
      DELAY_LINE_LOAD         <= '0;
      case (state_q)
        IDLE, DONE: begin
          if (TRAIN_START) begin
            lane_q     <= '0;
            TRAIN_BUSY <= 1'b1;
            TRAIN_DONE <= 1'b0;
            TRAIN_ERR  <= 1'b0;
            LANE_FAIL  <= '0;
            LANE_TAP   <= '0;
          end
        end
        LOAD: begin
          DELAY_LINE_LOAD[lane_q] <= 1'b1;
          tap_q        <= '0;
          run_len_q    <= '0;
          run_start_q  <= '0;
          best_len_q   <= '0;
          best_start_q <= '0;
        end
        CLEAR: begin
          EYE_MONITOR_CLEAR_FLAGS[lane_q] <= 1'b1;
          dirty_q <= 1'b0;
          oor_q   <= 1'b0;
          cnt_q   <= '0;
        end
        SETTLE: cnt_q <= (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
        SAMPLE: begin
          cnt_q   <= (cnt_q == SAMPLE_LAST) ? '0 : cnt_q + 1'b1;
          dirty_q <= dirty_q | flag_hit;
          oor_q   <= oor_q | oor_hit;
        end
        EVAL: begin
          run_len_q    <= run_len_d;
          run_start_q  <= run_start_d;
          best_len_q   <= best_len_d;
          best_start_q <= best_start_d;
          target_q     <= target_d;
          phase_q      <= 1'b0;
        end
        STEP: begin
          DELAY_LINE_MOVE[lane_q]      <= 1'b1;
          DELAY_LINE_DIRECTION[lane_q] <= 1'b1;
          tap_q <= tap_q + 1'b1;
        end
        CENTER: begin
          // Walk back one tap every other cycle so moves never abut.
          if (tap_q > target_q) begin
            if (!phase_q) begin
              DELAY_LINE_MOVE[lane_q]      <= 1'b1;
              DELAY_LINE_DIRECTION[lane_q] <= 1'b0;
              tap_q <= tap_q - 1'b1;
            end
            phase_q <= ~phase_q;
          end else begin
            LANE_TAP[lane_q*TAP_W +: TAP_W] <= target_q;
          end
        end
        FAIL: begin
          DELAY_LINE_LOAD[lane_q]         <= 1'b1;
          LANE_FAIL[lane_q]               <= 1'b1;
          LANE_TAP[lane_q*TAP_W +: TAP_W] <= '0;
        end
        NEXT: begin
          if (lane_q == LAST_LANE) begin
            TRAIN_BUSY <= 1'b0;
            TRAIN_DONE <= 1'b1;
            TRAIN_ERR  <= |LANE_FAIL;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iod_eye_train_ctrl.sv
// Bench for iod_eye_train_ctrl: a delay-line/eye-monitor model per lane
// follows the DUT strobes and produces flags from a clean-tap mask; a lane
// model predicts the centred tap from the mask, and a per-cycle monitor
// checks strobe rules and the held results.
module tb_iod_eye_train_ctrl;

  localparam int NL  = 2;
  localparam int TW  = 4;
  localparam int NT  = 16;
  localparam int SC  = 2;
  localparam int SMC = 3;
  localparam int MW  = 4;

  logic FAB_CLK = 1'b0;
  logic RESET, TRAIN_START;
  logic [NL-1:0]    early = '0, late = '0, oor_in = '0;
  logic [NL-1:0]    clr, mv, dir, ld, lf;
  logic             busy, done, err;
  logic [NL*TW-1:0] ltap;

  iod_eye_train_ctrl #(
    .NUM_LANES(NL), .TAP_W(TW), .NUM_TAPS(NT),
    .SETTLE_CYCLES(SC), .SAMPLE_CYCLES(SMC), .MIN_WINDOW(MW)
  ) dut (
    .FAB_CLK(FAB_CLK), .RESET(RESET), .TRAIN_START(TRAIN_START),
    .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late),
    .DELAY_LINE_OUT_OF_RANGE(oor_in),
    .EYE_MONITOR_CLEAR_FLAGS(clr), .DELAY_LINE_MOVE(mv),
    .DELAY_LINE_DIRECTION(dir), .DELAY_LINE_LOAD(ld),
    .TRAIN_BUSY(busy), .TRAIN_DONE(done), .TRAIN_ERR(err),
    .LANE_FAIL(lf), .LANE_TAP(ltap)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int vectors = 0;
  int miscompares = 0;

  // Environment configuration (written by the stimulus only)
  logic [NT-1:0] clean_mask [NL];
  int            oor_tap [NL];
  bit            all_early [NL];

  // Delay-line model state (written by the monitor only)
  int iod_tap [NL];
  int up_cnt [NL];
  int dn_cnt [NL];
  int ld_cnt [NL];
  logic [NL-1:0] mv_prev = '0, ld_prev = '0, clr_prev = '0, dir_prev = '0;
  logic rst_at_edge = 1'b1;

  // Expectations (written by the stimulus only)
  int            exp_tap [NL];
  bit            exp_fail [NL];
  int            exp_up [NL];
  int            exp_dn [NL];
  int            exp_ld [NL];
  logic [NL*TW-1:0] exp_ltap;
  logic [NL-1:0]    exp_lf;
  logic             exp_err;
  bit               res_en = 0;
  int b_up [NL];
  int b_dn [NL];
  int b_ld [NL];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Longest-first clean window over the swept taps, centred rounding down.
  function automatic void lane_model(input logic [NT-1:0] m, input int ot,
                                     output int tap, output bit fl,
                                     output int ups, output int dns, output int lds);
    int last, run, rs, best, bs;
    last = (ot >= 0 && ot < NT - 1) ? ot : NT - 1;
    run = 0; rs = 0; best = 0; bs = 0;
    for (int t = 0; t <= last; t++) begin
      if (m[t]) begin
        if (run == 0) rs = t;
        run++;
        if (run > best) begin best = run; bs = rs; end
      end else begin
        run = 0;
      end
    end
    ups = last;
    if (best >= MW) begin
      tap = bs + (best - 1) / 2; fl = 0; dns = last - tap; lds = 1;
    end else begin
      tap = 0; fl = 1; dns = 0; lds = 2;
    end
  endfunction

  always @(posedge FAB_CLK) rst_at_edge <= RESET;

  // Per-cycle monitor: strobe rules, delay-line model, flag generation, results.
  always @(negedge FAB_CLK) begin : monitor
    int  t;
    bit  dirty;
    chk("one_strobe", int'($countones({mv, ld, clr}) <= 1), 1);
    chk("strobe_width", int'(|((mv & mv_prev) | (ld & ld_prev) | (clr & clr_prev))), 0);
    if (!rst_at_edge) chk("dir_hold", int'(|((dir ^ dir_prev) & ~mv)), 0);
    if (!done) chk("err_without_done", int'(err), 0);
    if (done && res_en) begin
      chk("held_lane_tap", int'(ltap), int'(exp_ltap));
      chk("held_lane_fail", int'(lf), int'(exp_lf));
      chk("held_err", int'(err), int'(exp_err));
      chk("busy_with_done", int'(busy), 0);
    end
    for (int l = 0; l < NL; l++) begin
      t = iod_tap[l];
      if (ld[l]) begin
        t = 0;
        ld_cnt[l] <= ld_cnt[l] + 1;
      end else if (mv[l]) begin
        if (dir[l]) begin
          chk("move_up_in_range", int'(t < NT - 1), 1);
          if (t < NT - 1) t = t + 1;
          up_cnt[l] <= up_cnt[l] + 1;
        end else begin
          chk("move_dn_in_range", int'(t > 0), 1);
          if (t > 0) t = t - 1;
          dn_cnt[l] <= dn_cnt[l] + 1;
        end
      end
      iod_tap[l] <= t;
      dirty = all_early[l] || !clean_mask[l][t];
      early[l]  <= all_early[l] || (dirty && t[0] == 1'b0);
      late[l]   <= !all_early[l] && dirty && t[0] == 1'b1;
      oor_in[l] <= (t == oor_tap[l]);
    end
    mv_prev  <= mv;
    ld_prev  <= ld;
    clr_prev <= clr;
    dir_prev <= dir;
  end

  task automatic cfg(input logic [NT-1:0] m0, input int o0, input bit e0,
                     input logic [NT-1:0] m1, input int o1, input bit e1);
    clean_mask[0] = m0; oor_tap[0] = o0; all_early[0] = e0;
    clean_mask[1] = m1; oor_tap[1] = o1; all_early[1] = e1;
  endtask

  task automatic start_run();
    @(negedge FAB_CLK);
    res_en = 0;
    for (int l = 0; l < NL; l++) begin
      lane_model(all_early[l] ? '0 : clean_mask[l], oor_tap[l],
                 exp_tap[l], exp_fail[l], exp_up[l], exp_dn[l], exp_ld[l]);
      exp_ltap[l*TW +: TW] = TW'(exp_tap[l]);
      exp_lf[l] = exp_fail[l];
      b_up[l] = up_cnt[l]; b_dn[l] = dn_cnt[l]; b_ld[l] = ld_cnt[l];
    end
    exp_err = |exp_lf;
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("no_load_yet", int'(ld), 0);
    @(negedge FAB_CLK);
    chk("load_one_cycle_later", int'(ld), 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge FAB_CLK);
      n++;
    end
    chk("done_within_budget", int'(done), 1);
    res_en = 1;
    @(negedge FAB_CLK);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("lane%0d_tap", l), int'(ltap[l*TW +: TW]), exp_tap[l]);
      chk($sformatf("lane%0d_fail", l), int'(lf[l]), int'(exp_fail[l]));
      chk($sformatf("lane%0d_up_moves", l), up_cnt[l] - b_up[l], exp_up[l]);
      chk($sformatf("lane%0d_dn_moves", l), dn_cnt[l] - b_dn[l], exp_dn[l]);
      chk($sformatf("lane%0d_loads", l), ld_cnt[l] - b_ld[l], exp_ld[l]);
    end
    chk("train_err", int'(err), int'(exp_err));
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ld_before;
    RESET = 1'b1;
    TRAIN_START = 1'b0;
    cfg(16'h07E0, -1, 0, 16'h1FF8, -1, 0);
    repeat (3) @(negedge FAB_CLK);
    chk("reset_strobes", int'({mv, ld, clr, dir}), 0);
    chk("reset_status", int'({busy, done, err}), 0);
    chk("reset_results", int'({lf, ltap}), 0);
    RESET = 1'b0;
    repeat (2) @(negedge FAB_CLK);

    // Lane0 clean 5..10, lane1 clean 3..12: both centre on 7
    start_run();
    wait_done(1000);
    chk("A_lane_tap_literal", int'(ltap), 8'h77);
    chk("A_fail_literal", int'({lf, err}), 0);
    chk("A_lane0_up_literal", up_cnt[0] - b_up[0], 15);
    chk("A_lane0_dn_literal", dn_cnt[0] - b_dn[0], 8);

    // Lane0 always EARLY fails; lane1 equal windows 2..5 / 9..12 picks the first
    cfg(16'h0000, -1, 1, 16'h1E3C, -1, 0);
    repeat (2) @(negedge FAB_CLK);
    start_run();
    wait_done(1000);
    chk("B_lane_fail_literal", int'(lf), 1);
    chk("B_err_literal", int'(err), 1);
    chk("B_lane_tap_literal", int'(ltap), 8'h30);
    chk("B_lane0_loads_literal", ld_cnt[0] - b_ld[0], 2);

    // Lane0 clean from 4 with out-of-range at 8; lane1 clean 12..15
    cfg(16'hFFF0, 8, 0, 16'hF000, -1, 0);
    repeat (2) @(negedge FAB_CLK);
    start_run();
    wait_done(1000);
    chk("C_lane_tap_literal", int'(ltap), 8'hD6);
    chk("C_lane0_up_literal", up_cnt[0] - b_up[0], 8);

    // Lane0 clean 13..15 is below the minimum window
    cfg(16'hE000, -1, 0, 16'h07E0, -1, 0);
    repeat (2) @(negedge FAB_CLK);
    start_run();
    wait_done(1000);
    chk("D_lane_fail_literal", int'({lf, err}), 3'b011);
    chk("D_lane_tap_literal", int'(ltap), 8'h70);

    // Reset while sampling tap 3 of lane0, with a start pulse under reset
    cfg(16'h07E0, -1, 0, 16'h1FF8, -1, 0);
    repeat (2) @(negedge FAB_CLK);
    start_run();
    repeat (27) @(negedge FAB_CLK);
    RESET = 1'b1;
    @(negedge FAB_CLK);
    chk("midrun_reset_strobes", int'({mv, ld, clr, dir}), 0);
    chk("midrun_reset_status", int'({busy, done, err}), 0);
    chk("midrun_reset_results", int'({lf, ltap}), 0);
    ld_before = ld_cnt[0];
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    chk("reset_beats_start", int'(busy), 0);
    TRAIN_START = 1'b0;
    RESET = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    chk("idle_after_reset", int'(busy), 0);
    chk("no_load_after_reset", ld_cnt[0] - ld_before, 0);

    // Fresh retrain; a second start while busy must change nothing
    start_run();
    repeat (10) @(negedge FAB_CLK);
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
    wait_done(1000);
    chk("E_lane_tap_literal", int'(ltap), 8'h77);
    chk("E_lane0_loads_literal", ld_cnt[0] - b_ld[0], 1);

    repeat (2) @(negedge FAB_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
